// File: rtl/inst_fetch.sv
// Multi-cycle instruction fetch unit: owns the PC, issues one read per instruction over
// a valid/ready memory port and hands each word with its PC to decode.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        OUT,
        DROP
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic [31:0] inst_pc_q;
    logic        fault_q;

    logic        misaligned;
    logic        req_fire;
    logic [31:0] pc_plus4;

    assign misaligned = |pc_q[1:0];
    assign req_fire   = mem_req_valid && mem_req_ready;
    assign pc_plus4   = pc_q + 32'd4;

    // Outputs come only from state and registers, never from inputs.
    assign mem_req_valid = (state_q == REQ) && !misaligned;
    assign mem_req_addr  = pc_q;
    assign inst_valid    = (state_q == OUT);
    assign inst          = inst_q;
    assign inst_pc       = inst_pc_q;
    assign inst_fault    = fault_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            inst_q    <= 32'd0;
            inst_pc_q <= 32'd0;
            fault_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_pc;
                    end
                    state_q <= REQ;
                end
                REQ: begin
                    // A request accepted together with a redirect is still in flight.
                    if (redirect_valid) begin
                        pc_q    <= redirect_pc;
                        state_q <= req_fire ? DROP : REQ;
                    end else if (misaligned) begin
                        inst_q    <= 32'd0;
                        inst_pc_q <= pc_q;
                        fault_q   <= 1'b1;
                        state_q   <= OUT;
                    end else if (mem_req_ready) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        pc_q    <= redirect_pc;
                        state_q <= mem_rsp_valid ? REQ : DROP;
                    end else if (mem_rsp_valid) begin
                        inst_q    <= mem_rsp_err ? 32'd0 : mem_rsp_data;
                        inst_pc_q <= pc_q;
                        fault_q   <= mem_rsp_err;
                        state_q   <= OUT;
                    end
                end
                OUT: begin
                    if (redirect_valid) begin
                        pc_q    <= redirect_pc;
                        state_q <= REQ;
                    end else if (inst_ready) begin
                        pc_q    <= pc_plus4;
                        state_q <= REQ;
                    end
                end
                DROP: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_pc;
                    end
                    if (mem_rsp_valid) begin
                        state_q <= REQ;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
